// File: rtl/hermitian_product_stage.sv
`default_nettype none
// ============================================================================
// Module   : hermitian_product_stage
// Purpose  : Final stage of the Cholesky matrix-inverse chain. Takes the
//            lower-triangular inverse L^-1 and forms
//            A^-1 = (L^-1)^H * (L^-1).
//            The stage performs one complex multiply-accumulate per cycle.
//            It computes the lower triangle and mirrors it, conjugated, into
//            the upper triangle.
// Ports    : clk, rst_n             clock, asynchronous active-low reset
//            in_valid / in_ready    input handshake; in_ready is high in IDLE
//            Linv_real_in/imag_in   L^-1, row-major, N*N signed Q2.29 words
//            Ainv_real_out/imag_out A^-1, same packing, registered
//            out_valid              one-cycle pulse when a new result is ready
// Revision : 1.0  initial release
// ============================================================================
module hermitian_product_stage #(
    parameter int N      = 8,
    parameter int DATA_W = 32,
    parameter int FRAC   = 29
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*N*DATA_W-1:0]    Linv_real_in,
    input  logic [N*N*DATA_W-1:0]    Linv_imag_in,
    output logic [N*N*DATA_W-1:0]    Ainv_real_out,
    output logic [N*N*DATA_W-1:0]    Ainv_imag_out,
    output logic                     out_valid
);

    localparam int IW = $clog2(N);
    localparam int PW = 2 * DATA_W;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_compute = 2'd1;
    localparam logic [1:0] c_st_done    = 2'd2;

    localparam logic signed [DATA_W-1:0] c_max_d = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_min_d = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PW-1:0]     c_max_w = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0]     c_min_w = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [IW-1:0]            c_last  = IW'(N - 1);

    logic [1:0]             r_state;
    logic [IW-1:0]          r_i, r_j, r_k;
    logic signed [PW-1:0]   r_acc_re, r_acc_im;
    logic [N*N*DATA_W-1:0]  r_cap_re, r_cap_im;
    logic                   r_out_valid;

    logic signed [DATA_W-1:0] w_cap_re [N][N];
    logic signed [DATA_W-1:0] w_cap_im [N][N];

    logic signed [DATA_W-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [PW-1:0]     w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [PW-1:0]     w_term_re, w_term_im, w_acc_re_nxt, w_acc_im_nxt;
    logic signed [DATA_W-1:0] w_sat_re, w_sat_im, w_neg_im;
    logic                     w_last_k, w_row_end, w_wb;

    function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [PW-1:0] v);
        if (v > c_max_w)      return c_max_d;
        else if (v < c_min_w) return c_min_d;
        else                  return v[DATA_W-1:0];
    endfunction

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = r_out_valid;

    // Since j <= i <= k, only lower-triangle words of the captured copy are
    // ever addressed, so the upper-triangle input contents are irrelevant.
    assign w_a_re = w_cap_re[r_k][r_i];
    assign w_a_im = w_cap_im[r_k][r_i];
    assign w_b_re = w_cap_re[r_k][r_j];
    assign w_b_im = w_cap_im[r_k][r_j];

    // conj(a) * b = (ar*br + ai*bi) + j(ar*bi - ai*br)
    assign w_p_rr = PW'(w_a_re) * PW'(w_b_re);
    assign w_p_ii = PW'(w_a_im) * PW'(w_b_im);
    assign w_p_ri = PW'(w_a_re) * PW'(w_b_im);
    assign w_p_ir = PW'(w_a_im) * PW'(w_b_re);

    assign w_term_re    = (w_p_rr + w_p_ii) >>> FRAC;
    assign w_term_im    = (w_p_ri - w_p_ir) >>> FRAC;
    assign w_acc_re_nxt = r_acc_re + w_term_re;
    assign w_acc_im_nxt = r_acc_im + w_term_im;

    assign w_sat_re = f_sat(w_acc_re_nxt);
    assign w_sat_im = f_sat(w_acc_im_nxt);
    // The most negative value has no positive twin; clamp its negation.
    assign w_neg_im = (w_sat_im == c_min_d) ? c_max_d : -w_sat_im;

    assign w_last_k  = (r_k == c_last);
    assign w_row_end = (r_j == r_i);
    assign w_wb      = (r_state == c_st_compute) && w_last_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cap_re    <= '0;
            r_cap_im    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_cap_re <= Linv_real_in;
                        r_cap_im <= Linv_imag_in;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        r_state  <= c_st_compute;
                    end
                end
                c_st_compute: begin
                    if (w_last_k) begin
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        if (w_row_end) begin
                            if (r_i == c_last) begin
                                r_i         <= '0;
                                r_j         <= '0;
                                r_k         <= '0;
                                r_state     <= c_st_done;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_i <= r_i + IW'(1);
                                r_j <= '0;
                                r_k <= r_i + IW'(1);
                            end
                        end else begin
                            r_j <= r_j + IW'(1);
                            r_k <= r_i;
                        end
                    end else begin
                        r_acc_re <= w_acc_re_nxt;
                        r_acc_im <= w_acc_im_nxt;
                        r_k      <= r_k + IW'(1);
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    // Per-element views of the captured copy and per-element result registers.
    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            localparam int c_lsb = (gr * N + gc) * DATA_W;
            logic signed [DATA_W-1:0] r_el_re, r_el_im;

            assign w_cap_re[gr][gc] = r_cap_re[c_lsb +: DATA_W];
            assign w_cap_im[gr][gc] = r_cap_im[c_lsb +: DATA_W];
            assign Ainv_real_out[c_lsb +: DATA_W] = r_el_re;
            assign Ainv_imag_out[c_lsb +: DATA_W] = r_el_im;

            if (gr == gc) begin : g_diag
                // Diagonal of a Hermitian matrix is real.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_el_re <= '0;
                        r_el_im <= '0;
                    end else if (w_wb && r_i == IW'(gr) && r_j == IW'(gc)) begin
                        r_el_re <= w_sat_re;
                        r_el_im <= '0;
                    end
                end
            end else if (gr > gc) begin : g_lower
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_el_re <= '0;
                        r_el_im <= '0;
                    end else if (w_wb && r_i == IW'(gr) && r_j == IW'(gc)) begin
                        r_el_re <= w_sat_re;
                        r_el_im <= w_sat_im;
                    end
                end
            end else begin : g_upper
                // Mirror of the lower element (gc, gr), conjugated.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_el_re <= '0;
                        r_el_im <= '0;
                    end else if (w_wb && r_i == IW'(gc) && r_j == IW'(gr)) begin
                        r_el_re <= w_sat_re;
                        r_el_im <= w_neg_im;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hermitian_product_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_hermitian_product_stage
// Purpose  : Self-checking bench for hermitian_product_stage. A matrix-level
//            reference model computes conj(L)^T * L from the masked lower
//            triangle and is compared with the DUT result and latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_hermitian_product_stage;

    localparam int N    = 8;
    localparam int W    = 32;
    localparam int FRAC = 29;
    localparam int LAT  = 120;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready, out_valid;
    logic [N*N*W-1:0] lr_in = '0, li_in = '0;
    logic [N*N*W-1:0] ar_out, ai_out;

    int checks   = 0;
    int failures = 0;

    int m_re [N][N];
    int m_im [N][N];
    int e_re [N][N];
    int e_im [N][N];

    always #5 clk = ~clk;

    hermitian_product_stage #(.N(N), .DATA_W(W), .FRAC(FRAC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .Linv_real_in  (lr_in),
        .Linv_imag_in  (li_in),
        .Ainv_real_out (ar_out),
        .Ainv_imag_out (ai_out),
        .out_valid     (out_valid)
    );

    function automatic int sat(input longint v);
        if (v > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
        return int'(v);
    endfunction

    // A = L^H * L with L the lower triangle of m (upper treated as 0).
    task automatic model();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint sre = 0, sim = 0;
                for (int k = 0; k < N; k++) begin
                    longint ar, ai, br, bi;
                    ar = (i <= k) ? longint'(m_re[k][i]) : 0;
                    ai = (i <= k) ? longint'(m_im[k][i]) : 0;
                    br = (j <= k) ? longint'(m_re[k][j]) : 0;
                    bi = (j <= k) ? longint'(m_im[k][j]) : 0;
                    sre += (ar * br + ai * bi) >>> FRAC;
                    sim += (ar * bi - ai * br) >>> FRAC;
                end
                if (j <= i) begin
                    e_re[i][j] = sat(sre);
                    e_im[i][j] = (i == j) ? 0 : sat(sim);
                end
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++) begin
                e_re[i][j] = e_re[j][i];
                e_im[i][j] = (e_im[j][i] == 32'h80000000) ? 32'h7FFFFFFF : -e_im[j][i];
            end
    endtask

    task automatic load_bus();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                lr_in[(r*N+c)*W +: W] = m_re[r][c];
                li_in[(r*N+c)*W +: W] = m_im[r][c];
            end
    endtask

    // Fills the lower triangle per mode; upper triangle always gets garbage.
    task automatic fill(input int mode, input int val);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (c > r) begin
                    m_re[r][c] = int'($urandom);
                    m_im[r][c] = int'($urandom);
                end else if (mode == 0) begin
                    m_re[r][c] = (r == c) ? val : 0;
                    m_im[r][c] = 0;
                end else if (mode == 1) begin
                    m_re[r][c] = val;
                    m_im[r][c] = 0;
                end else if (mode == 2) begin
                    m_re[r][c] = int'($urandom_range(32'h3FFFFFFF)) - 32'sh20000000;
                    m_im[r][c] = int'($urandom_range(32'h3FFFFFFF)) - 32'sh20000000;
                end else begin
                    m_re[r][c] = int'($urandom);
                    m_im[r][c] = int'($urandom);
                end
            end
    endtask

    function automatic int get_re(input int r, input int c);
        logic [W-1:0] v;
        v = ar_out[(r*N+c)*W +: W];
        return int'(v);
    endfunction

    function automatic int get_im(input int r, input int c);
        logic [W-1:0] v;
        v = ai_out[(r*N+c)*W +: W];
        return int'(v);
    endfunction

    task automatic check_matrix(input string name);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (get_re(r, c) !== e_re[r][c] || get_im(r, c) !== e_im[r][c]) begin
                    failures++;
                    $display("FAIL %s A[%0d][%0d] got=%h+j%h exp=%h+j%h", name, r, c,
                             get_re(r, c), get_im(r, c), e_re[r][c], e_im[r][c]);
                end
            end
    endtask

    // Counts cycles from the acceptance edge to out_valid (bounded).
    task automatic wait_result(input string name);
        int lat;
        bit seen;
        lat = 0;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || lat !== LAT) begin
            failures++;
            $display("FAIL %s latency got=%0d seen=%0d exp=%0d", name, lat, seen, LAT);
        end
        check_matrix(name);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s after-pulse out_valid=%b in_ready=%b exp 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic run(input string name);
        model();
        load_bus();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready before accept got=%b exp=1", name, in_ready);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(name);
    endtask

    task automatic check_zero(input string name);
        bit bad;
        bad = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (get_re(r, c) !== 0 || get_im(r, c) !== 0) bad = 1'b1;
        checks++;
        if (bad || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s outputs-zero got nonzero=%b out_valid=%b exp 0/0", name, bad, out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset in_ready got=%b exp=1", in_ready);
        end
        check_zero("reset_release");
    endtask

    task automatic test_identity();
        fill(0, 32'h20000000);
        run("identity");
    endtask

    task automatic test_scaled();
        fill(0, 32'h10000000);
        run("scaled");
        checks++;
        if (get_re(3, 3) !== 32'h08000000 || get_re(3, 2) !== 0) begin
            failures++;
            $display("FAIL scaled_const A33=%h A32=%h exp 08000000/0", get_re(3, 3), get_re(3, 2));
        end
    endtask

    task automatic test_complex();
        fill(0, 32'h20000000);
        m_im[1][0] = 32'h10000000;
        run("complex");
        checks++;
        if (get_re(0, 0) !== 32'h28000000 || get_im(1, 0) !== 32'h10000000 ||
            get_im(0, 1) !== 32'hF0000000 || get_re(1, 1) !== 32'h20000000) begin
            failures++;
            $display("FAIL complex_const A00re=%h A10im=%h A01im=%h A11re=%h exp 28000000/10000000/F0000000/20000000",
                     get_re(0, 0), get_im(1, 0), get_im(0, 1), get_re(1, 1));
        end
    endtask

    task automatic test_saturation();
        fill(1, 32'h7FFFFFFF);
        run("saturation");
        checks++;
        if (get_re(0, 0) !== 32'h7FFFFFFF) begin
            failures++;
            $display("FAIL sat_const A00re got=%h exp=7FFFFFFF", get_re(0, 0));
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            fill((t % 2 == 0) ? 2 : 3, 0);
            run("random");
        end
    endtask

    task automatic test_back_to_back();
        int  lat;
        bit  seen, early_ready;
        fill(2, 0);
        model();
        load_bus();
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Different matrix held on the bus with in_valid high through COMPUTE.
        fill(3, 0);
        load_bus();
        lat = 0; seen = 1'b0; early_ready = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            if (in_ready) early_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || lat !== LAT || early_ready) begin
            failures++;
            $display("FAIL busy first latency=%0d seen=%0d early_ready=%0d exp %0d/1/0", lat, seen, early_ready, LAT);
        end
        check_matrix("busy_first");
        model();
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL busy done->idle out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result("busy_second");
    endtask

    task automatic test_reset_mid();
        fill(0, 32'h20000000);
        load_bus();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_async");
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check_zero("reset_mid_held");
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("reset_mid_rerun");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_scaled();
        test_complex();
        test_saturation();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
